// File: rtl/dmem_arbiter.sv
// Two-port grant/issue/respond sequencer owning the single-ported DataMem controls.
// Latency: request sampled in IDLE -> gnt next cycle -> done 3 cycles after sampling; one access per 3 cycles.
// Backpressure: a requester holds req until gnt; DMEM_ARB_RR_EN selects round-robin on ties, else port 0 wins.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              we_q;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
    logic last;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        win = p1_req & ~p0_req;
        if (p0_req && p1_req) begin
            win = ~last;
        end
    end
`else
    assign win = p1_req & ~p0_req;
`endif

    assign win_we    = win ? p1_we    : p0_we;
    assign win_addr  = win ? p1_addr  : p0_addr;
    assign win_wdata = win ? p1_wdata : p0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            p0_gnt      <= 1'b0;
            p1_gnt      <= 1'b0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            busy        <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last        <= 1'b1;
`endif
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        state       <= ACCESS;
                        owner       <= win;
                        we_q        <= win_we;
                        mem_address <= win_addr;
                        mem_wdata   <= win_wdata;
                        mem_write   <= win_we;
                        mem_read    <= ~win_we;
                        p0_gnt      <= ~win;
                        p1_gnt      <= win;
                        busy        <= 1'b1;
`ifdef DMEM_ARB_RR_EN
                        last        <= win;
`endif
                    end
                end
                ACCESS: begin
                    // The memory acts on this edge; controls drop together with it.
                    state     <= RESP;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!we_q) begin
                        if (owner) begin
                            p1_rdata <= mem_rdata;
                        end else begin
                            p0_rdata <= mem_rdata;
                        end
                    end
                    p0_done <= ~owner;
                    p1_done <= owner;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized rounds against a cycle-level behavioural model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 20) return 32'h5555_5555;
        if (i == 'h28) return 32'hAAAA_AAAA;
        return 32'h1357_0000 + i * 32'h0101_0011;
    endfunction

    // DataMem stand-in: byte address [7:0], registered read.
    logic [31:0] dmem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_read) mem_rdata <= dmem[mem_address[7:0]];
            if (mem_write) dmem[mem_address[7:0]] <= mem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata [2];
    bit          pend [2];
    int          req_cyc [2];
    int          remaining [2];
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    int          prev_gnt;
    bit          last_ref;
    bit          last_we;
    int          grant_w;
    bit          out_vld;
    int          out_port, out_cyc;
    bit          out_we;
    logic [31:0] out_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_req(input int k, input bit v);
        if (k == 0) p0_req = v;
        else p1_req = v;
    endtask

    // One clock: predict grant/done from request history, then compare every output.
    task automatic step();
        bit e0, e1, d0, d1;
        @(negedge clk);
        cyc++;
        grant_w = -1;
        e0 = pend[0] && (req_cyc[0] < cyc);
        e1 = pend[1] && (req_cyc[1] < cyc);
        if (cyc >= prev_gnt + 3) begin
            if (e0 && e1) begin
`ifdef DMEM_ARB_RR_EN
                grant_w = last_ref ? 0 : 1;
`else
                grant_w = 0;
`endif
            end else if (e0) grant_w = 0;
            else if (e1) grant_w = 1;
        end
        d0 = out_vld && out_port == 0 && cyc == out_cyc + 2;
        d1 = out_vld && out_port == 1 && cyc == out_cyc + 2;
        if (d0 || d1) begin
            if (!out_we) exp_rdata[out_port] = out_rdata;
            out_vld = 1'b0;
        end
        check("p0_gnt", p0_gnt, grant_w == 0);
        check("p1_gnt", p1_gnt, grant_w == 1);
        check("p0_done", p0_done, d0);
        check("p1_done", p1_done, d1);
        check("p0_rdata", p0_rdata, exp_rdata[0]);
        check("p1_rdata", p1_rdata, exp_rdata[1]);
        if (grant_w >= 0) begin
            prev_gnt  = cyc;
            last_ref  = (grant_w == 1);
            last_we   = m_we[grant_w];
            out_vld   = 1'b1;
            out_port  = grant_w;
            out_cyc   = cyc;
            out_we    = m_we[grant_w];
            if (m_we[grant_w]) ref_mem[m_addr[grant_w][7:0]] = m_wd[grant_w];
            else out_rdata = ref_mem[m_addr[grant_w][7:0]];
            check("mem_address", mem_address, m_addr[grant_w]);
            if (m_we[grant_w]) check("mem_wdata", mem_wdata, m_wd[grant_w]);
            remaining[grant_w]--;
            if (remaining[grant_w] == 0) begin
                pend[grant_w] = 1'b0;
                set_req(grant_w, 1'b0);
            end
        end
        check("busy", busy, (cyc - prev_gnt) <= 1);
        check("mem_write", mem_write, (cyc == prev_gnt) && last_we);
        check("mem_read", mem_read, (cyc == prev_gnt) && !last_we);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0;
            remaining[k] = 0;
            exp_rdata[k] = '0;
        end
        out_vld  = 1'b0;
        prev_gnt = -100;
        last_ref = 1'b1;
        last_we  = 1'b0;
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_p0_done", p0_done, 0);
        check("rst_p1_done", p1_done, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
    endtask

    // Issue n0/n1 accesses (req held across repeats); rst_phase >= 0 resets that many cycles after the first grant.
    task automatic round(input int n0, input int n1, input bit we0, input bit we1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1, input int rst_phase);
        bit to;
        to = 1'b1;
        remaining[0] = n0;
        remaining[1] = n1;
        m_we[0] = we0; m_addr[0] = a0; m_wd[0] = w0;
        m_we[1] = we1; m_addr[1] = a1; m_wd[1] = w1;
        p0_we = we0; p0_addr = a0; p0_wdata = w0;
        p1_we = we1; p1_addr = a1; p1_wdata = w1;
        pend[0] = (n0 > 0);
        pend[1] = (n1 > 0);
        req_cyc[0] = cyc;
        req_cyc[1] = cyc;
        p0_req = (n0 > 0);
        p1_req = (n1 > 0);
        for (int i = 0; i < 60; i++) begin
            if (!pend[0] && !pend[1] && !out_vld) begin
                to = 1'b0;
                break;
            end
            step();
            if (rst_phase >= 0 && grant_w >= 0) begin
                repeat (rst_phase) step();
                apply_reset();
                to = 1'b0;
                break;
            end
        end
        check("round_timeout", to, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          r0, r1;
        bit          rw0, rw1;
        logic [31:0] ra0, ra1, rd0, rd1;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        apply_reset();
        idle(1);

        round(1, 0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0, -1);
        round(1, 0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, -1);
        idle(2);
        round(0, 1, 1'b0, 1'b0, 32'h0, 32'd20, 32'h0, 32'h0, -1);
        idle(1);
        round(2, 2, 1'b0, 1'b0, 32'h28, 32'd20, 32'h0, 32'h0, -1);
        // Reasserted in the done cycle each time.
        for (int i = 0; i < 3; i++) round(1, 0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, -1);
        idle(1);
        round(1, 0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1234_5678, 32'h0, 0);
        idle(2);
        round(1, 0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0, -1);
        round(0, 1, 1'b0, 1'b0, 32'h0, 32'h28, 32'h0, 32'h0, -1);
        round(1, 0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0, 1);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            r0 = $urandom_range(0, 2);
            r1 = $urandom_range(0, 2);
            if (r0 == 0 && r1 == 0) r0 = 1;
            rw0 = $urandom_range(0, 1);
            rw1 = $urandom_range(0, 1);
            ra0 = $urandom; ra1 = $urandom;
            rd0 = $urandom; rd1 = $urandom;
            if ($urandom_range(0, 3) == 0) ra1 = ra0;
            round(r0, r1, rw0, rw1, ra0, ra1, rd0, rd1, -1);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
